// File: rtl/fuzzy_sweep_seq.sv
// Input-grid sweep sequencer for the Fuzzy_1 type-2 controller: walks (i,j) row-major,
// settles, captures saida_defuzzy into a valid/ready stream. Define FUZZY_SWEEP_CHECKSUM_EN for the running checksum.
module fuzzy_sweep_seq #(
   parameter int DATA_W     = 8,
   parameter int STEP       = 1,
   parameter int LIMIT      = 255,
   parameter int MIN_CLAMP  = 1,
   parameter int MAX_CLAMP  = 254,
   parameter int SETTLE_CYC = 14
) (
   input  logic              clk_0,
   input  logic              Srst,
   input  logic              start,
   input  logic              abort,
   output logic [DATA_W-1:0] Entrada_01,
   output logic [DATA_W-1:0] Entrada_02,
   input  logic [DATA_W-1:0] saida_defuzzy,
   output logic [DATA_W-1:0] res_data,
   output logic [DATA_W-1:0] res_i,
   output logic [DATA_W-1:0] res_j,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic              done,
   output logic [15:0]       checksum
);

   localparam int IDX_W = DATA_W + 1;
   localparam int SUM_W = IDX_W + 1;
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_EMIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] ent1_q, ent1_d, ent2_q, ent2_d;
   logic [DATA_W-1:0] res_data_q, res_data_d, res_i_q, res_i_d, res_j_q, res_j_d;
   logic              res_valid_q, res_valid_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [SUM_W-1:0]  i_step_s, j_step_s;
   logic              i_more_s, j_more_s, start_ok_s, settle_end_s, hs_s;

   function automatic logic [DATA_W-1:0] clamp_f(input logic [IDX_W-1:0] x);
      logic [DATA_W-1:0] r;
      if (x < IDX_W'(MIN_CLAMP)) begin
         r = DATA_W'(MIN_CLAMP);
      end else if (x > IDX_W'(MAX_CLAMP)) begin
         r = DATA_W'(MAX_CLAMP);
      end else begin
         r = x[DATA_W-1:0];
      end
      return r;
   endfunction

   // One extra bit over the index so the bound test never sees a wrapped sum
   assign i_step_s     = {1'b0, i_q} + SUM_W'(STEP);
   assign j_step_s     = {1'b0, j_q} + SUM_W'(STEP);
   assign i_more_s     = (i_step_s < SUM_W'(LIMIT));
   assign j_more_s     = (j_step_s < SUM_W'(LIMIT));
   assign start_ok_s   = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign settle_end_s = (state_q == ST_SETTLE) && (cnt_q == CNT_W'(SETTLE_CYC - 1));
   assign hs_s         = (state_q == ST_EMIT) && res_valid_q && res_ready;

   // State register
   always_ff @(posedge clk_0) begin
      if (Srst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok_s) state_d = ST_SETTLE;
            else            state_d = ST_IDLE;
         end
         ST_SETTLE: begin
            if (abort)             state_d = ST_IDLE;
            else if (settle_end_s) state_d = ST_EMIT;
            else                   state_d = ST_SETTLE;
         end
         ST_EMIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (hs_s) begin
               if (j_more_s || i_more_s) state_d = ST_SETTLE;
               else                      state_d = ST_DONE;
            end else begin
               state_d = ST_EMIT;
            end
         end
         ST_DONE: begin
            if (start_ok_s) state_d = ST_SETTLE;
            else            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath logic
   always_comb begin
      i_d         = i_q;
      j_d         = j_q;
      cnt_d       = cnt_q;
      ent1_d      = ent1_q;
      ent2_d      = ent2_q;
      res_data_d  = res_data_q;
      res_i_d     = res_i_q;
      res_j_d     = res_j_q;
      res_valid_d = res_valid_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok_s) begin
               i_d    = {IDX_W{1'b0}};
               j_d    = {IDX_W{1'b0}};
               cnt_d  = {CNT_W{1'b0}};
               ent1_d = clamp_f({IDX_W{1'b0}});
               ent2_d = clamp_f({IDX_W{1'b0}});
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               cnt_d  = {CNT_W{1'b0}};
               ent1_d = DATA_W'(MIN_CLAMP);
               ent2_d = DATA_W'(MIN_CLAMP);
            end else if (settle_end_s) begin
               cnt_d       = {CNT_W{1'b0}};
               res_data_d  = saida_defuzzy;
               res_i_d     = ent1_q;
               res_j_d     = ent2_q;
               res_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_EMIT: begin
            if (abort) begin
               res_valid_d = 1'b0;
               cnt_d       = {CNT_W{1'b0}};
               ent1_d      = DATA_W'(MIN_CLAMP);
               ent2_d      = DATA_W'(MIN_CLAMP);
            end else if (hs_s) begin
               res_valid_d = 1'b0;
               cnt_d       = {CNT_W{1'b0}};
               if (j_more_s) begin
                  j_d    = j_step_s[IDX_W-1:0];
                  ent2_d = clamp_f(j_step_s[IDX_W-1:0]);
               end else if (i_more_s) begin
                  i_d    = i_step_s[IDX_W-1:0];
                  j_d    = {IDX_W{1'b0}};
                  ent1_d = clamp_f(i_step_s[IDX_W-1:0]);
                  ent2_d = clamp_f({IDX_W{1'b0}});
               end else begin
                  j_d = j_q;
               end
            end else begin
               res_valid_d = res_valid_q;
            end
         end
         default: begin
            res_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d == ST_SETTLE) || (state_d == ST_EMIT);
      done_d = (state_d == ST_DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk_0) begin
      if (Srst) begin
         i_q         <= {IDX_W{1'b0}};
         j_q         <= {IDX_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         ent1_q      <= DATA_W'(MIN_CLAMP);
         ent2_q      <= DATA_W'(MIN_CLAMP);
         res_data_q  <= {DATA_W{1'b0}};
         res_i_q     <= {DATA_W{1'b0}};
         res_j_q     <= {DATA_W{1'b0}};
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         i_q         <= i_d;
         j_q         <= j_d;
         cnt_q       <= cnt_d;
         ent1_q      <= ent1_d;
         ent2_q      <= ent2_d;
         res_data_q  <= res_data_d;
         res_i_q     <= res_i_d;
         res_j_q     <= res_j_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef FUZZY_SWEEP_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   // Checksum accumulates every consumed result, including one consumed under abort
   always_comb begin
      if (start_ok_s) begin
         checksum_d = 16'd0;
      end else if (hs_s) begin
         checksum_d = checksum_q + 16'(res_data_q);
      end else begin
         checksum_d = checksum_q;
      end
   end

   // Checksum register
   always_ff @(posedge clk_0) begin
      if (Srst) begin
         checksum_q <= 16'd0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 16'd0;
`endif

   assign Entrada_01 = ent1_q;
   assign Entrada_02 = ent2_q;
   assign res_data   = res_data_q;
   assign res_i      = res_i_q;
   assign res_j      = res_j_q;
   assign res_valid  = res_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_fuzzy_sweep_seq.sv
// Randomised self-checking bench for fuzzy_sweep_seq: two instances (small grid, wide-step grid)
// checked against a queue of points generated from the sweep rules.
module tb_fuzzy_sweep_seq;

   localparam int DW       = 8;
   localparam int A_LIMIT  = 4;
   localparam int A_STEP   = 1;
   localparam int A_SETTLE = 14;
   localparam int B_LIMIT  = 256;
   localparam int B_STEP   = 127;
   localparam int B_SETTLE = 4;
   localparam int MINC     = 1;
   localparam int MAXC     = 254;

   typedef struct {int i; int j; int d;} pt_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic srst, start_a, abort_a, ready_a, start_b, abort_b, ready_b;
   logic [7:0] mask_a;
   logic [DW-1:0] a_e1, a_e2, a_sd, a_rd, a_ri, a_rj;
   logic [DW-1:0] b_e1, b_e2, b_sd, b_rd, b_ri, b_rj;
   logic a_valid, a_busy, a_done, b_valid, b_busy, b_done;
   logic [15:0] a_ck, b_ck;

   assign a_sd = a_e1 ^ a_e2 ^ mask_a;
   assign b_sd = b_e1 ^ b_e2;

   fuzzy_sweep_seq #(.DATA_W(DW), .STEP(A_STEP), .LIMIT(A_LIMIT), .MIN_CLAMP(MINC),
                     .MAX_CLAMP(MAXC), .SETTLE_CYC(A_SETTLE)) dut_a (
      .clk_0(clk), .Srst(srst), .start(start_a), .abort(abort_a),
      .Entrada_01(a_e1), .Entrada_02(a_e2), .saida_defuzzy(a_sd),
      .res_data(a_rd), .res_i(a_ri), .res_j(a_rj), .res_valid(a_valid), .res_ready(ready_a),
      .busy(a_busy), .done(a_done), .checksum(a_ck));

   fuzzy_sweep_seq #(.DATA_W(DW), .STEP(B_STEP), .LIMIT(B_LIMIT), .MIN_CLAMP(MINC),
                     .MAX_CLAMP(MAXC), .SETTLE_CYC(B_SETTLE)) dut_b (
      .clk_0(clk), .Srst(srst), .start(start_b), .abort(abort_b),
      .Entrada_01(b_e1), .Entrada_02(b_e2), .saida_defuzzy(b_sd),
      .res_data(b_rd), .res_i(b_ri), .res_j(b_rj), .res_valid(b_valid), .res_ready(ready_b),
      .busy(b_busy), .done(b_done), .checksum(b_ck));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: enumerate the grid from the loop rules
   pt_t exp_a[$];
   pt_t exp_b[$];
   int  exp_sum_a;

   function automatic int clampv(input int x);
      return (x < MINC) ? MINC : ((x > MAXC) ? MAXC : x);
   endfunction

   task automatic load_a();
      exp_a.delete();
      exp_sum_a = 0;
      for (int i = 0; i < A_LIMIT; i += A_STEP)
         for (int j = 0; j < A_LIMIT; j += A_STEP) begin
            pt_t p;
            p.i = clampv(i);
            p.j = clampv(j);
            p.d = p.i ^ p.j ^ int'(mask_a);
            exp_a.push_back(p);
            exp_sum_a += p.d;
         end
   endtask

   task automatic load_b();
      exp_b.delete();
      for (int i = 0; i < B_LIMIT; i += B_STEP)
         for (int j = 0; j < B_LIMIT; j += B_STEP) begin
            pt_t p;
            p.i = clampv(i);
            p.j = clampv(j);
            p.d = p.i ^ p.j;
            exp_b.push_back(p);
         end
   endtask

   function automatic int exp_ck_a();
`ifdef FUZZY_SWEEP_CHECKSUM_EN
      return exp_sum_a % 65536;
`else
      return 0;
`endif
   endfunction

   // Monitors: sample away from the active edge
   int  hs_cnt_a = 0, hs_cnt_b = 0;
   bit  hold_a = 0, prev_valid_a = 0, first_a = 0, spacing_on = 0;
   int  hold_i, hold_j, hold_d, start_cyc_a = 0, last_rise_a = 0;

   always @(negedge clk) begin
      if (hold_a && a_valid) begin
         check_eq("a_hold_i", int'(a_ri), hold_i);
         check_eq("a_hold_j", int'(a_rj), hold_j);
         check_eq("a_hold_d", int'(a_rd), hold_d);
      end
      if (a_valid && ready_a) begin
         hs_cnt_a++;
         if (exp_a.size() == 0) begin
            check_eq("a_extra_result", 1, 0);
         end else begin
            pt_t e;
            e = exp_a.pop_front();
            check_eq("a_res_i", int'(a_ri), e.i);
            check_eq("a_res_j", int'(a_rj), e.j);
            check_eq("a_res_data", int'(a_rd), e.d);
         end
      end
      if (a_valid && !prev_valid_a) begin
         if (first_a) begin
            check_eq("a_first_latency", cyc - start_cyc_a, A_SETTLE + 1);
            first_a = 0;
         end else if (spacing_on) begin
            check_eq("a_spacing", cyc - last_rise_a, A_SETTLE + 1);
         end
         last_rise_a = cyc;
      end
      hold_a       = a_valid && !ready_a && !abort_a && !srst;
      hold_i       = int'(a_ri);
      hold_j       = int'(a_rj);
      hold_d       = int'(a_rd);
      prev_valid_a = a_valid;
   end

   always @(negedge clk) begin
      if (b_valid && ready_b) begin
         hs_cnt_b++;
         if (exp_b.size() == 0) begin
            check_eq("b_extra_result", 1, 0);
         end else begin
            pt_t e;
            e = exp_b.pop_front();
            check_eq("b_res_i", int'(b_ri), e.i);
            check_eq("b_res_j", int'(b_rj), e.j);
            check_eq("b_res_data", int'(b_rd), e.d);
         end
      end
   end

   task automatic pulse_start_a();
      @(posedge clk); #1;
      start_a     = 1'b1;
      start_cyc_a = cyc;
      first_a     = 1;
      @(posedge clk); #1;
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int maxc, input bit rnd);
      int t;
      t = 0;
      while (!a_done && t < maxc) begin
         @(posedge clk); #1;
         start_a = 1'b0;
         t++;
         if (rnd) begin
            ready_a = ($urandom_range(0, 2) == 0);
            if (a_busy && ($urandom_range(0, 7) == 0)) start_a = 1'b1;
         end
      end
      start_a = 1'b0;
      ready_a = 1'b1;
      check_eq("a_done_reached", int'(a_done), 1);
   endtask

   task automatic wait_hs_a(input int target, input int maxc);
      int t;
      t = 0;
      while (hs_cnt_a < target && t < maxc) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq("a_hs_reached", int'(hs_cnt_a >= target), 1);
   endtask

   task automatic check_reset_a(input string tag);
      check_eq({tag, "_e1"}, int'(a_e1), MINC);
      check_eq({tag, "_e2"}, int'(a_e2), MINC);
      check_eq({tag, "_rd"}, int'(a_rd), 0);
      check_eq({tag, "_ri"}, int'(a_ri), 0);
      check_eq({tag, "_rj"}, int'(a_rj), 0);
      check_eq({tag, "_valid"}, int'(a_valid), 0);
      check_eq({tag, "_busy"}, int'(a_busy), 0);
      check_eq({tag, "_done"}, int'(a_done), 0);
      check_eq({tag, "_ck"}, int'(a_ck), 0);
   endtask

   initial begin
      int base, t;
      srst = 1'b1; start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1; mask_a = 8'd0;
      repeat (3) @(posedge clk);
      #1 srst = 1'b0;
      check_reset_a("rst");

      // Full sweep, ready held high
      mask_a = 8'($urandom_range(0, 255));
      load_a();
      spacing_on = 1;
      ready_a    = 1'b1;
      base       = hs_cnt_a;
      pulse_start_a();
      wait_done_a(1000, 0);
      check_eq("s1_count", hs_cnt_a - base, 16);
      check_eq("s1_left", exp_a.size(), 0);
      check_eq("s1_busy", int'(a_busy), 0);
      check_eq("s1_e1_last", int'(a_e1), 3);
      check_eq("s1_e2_last", int'(a_e2), 3);
      check_eq("s1_ck", int'(a_ck), exp_ck_a());

      // Random backpressure plus stray starts while busy
      spacing_on = 0;
      mask_a     = 8'($urandom_range(0, 255));
      load_a();
      base = hs_cnt_a;
      pulse_start_a();
      wait_done_a(5000, 1);
      check_eq("s2_count", hs_cnt_a - base, 16);
      check_eq("s2_left", exp_a.size(), 0);
      check_eq("s2_ck", int'(a_ck), exp_ck_a());

      // Abort on the fifth result while it is stalled
      load_a();
      base = hs_cnt_a;
      pulse_start_a();
      wait_hs_a(base + 4, 500);
      ready_a = 1'b0;
      t = 0;
      while (!a_valid && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq("ab_valid_seen", int'(a_valid), 1);
      abort_a = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0;
      check_eq("ab_valid", int'(a_valid), 0);
      check_eq("ab_e1", int'(a_e1), MINC);
      check_eq("ab_e2", int'(a_e2), MINC);
      check_eq("ab_busy", int'(a_busy), 0);
      check_eq("ab_done", int'(a_done), 0);
      check_eq("ab_hs", hs_cnt_a - base, 4);
      exp_a.delete();
      repeat (5) @(posedge clk);
      #1 check_eq("ab_idle_valid", int'(a_valid), 0);

      // Restart after abort begins again at (1,1)
      load_a();
      ready_a = 1'b1;
      base    = hs_cnt_a;
      pulse_start_a();
      wait_done_a(1000, 0);
      check_eq("rs_count", hs_cnt_a - base, 16);
      check_eq("rs_left", exp_a.size(), 0);

      // Wide step: raw 0,127,254 clamp to 1,127,254
      load_b();
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      t = 0;
      while (!b_done && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq("b_done_reached", int'(b_done), 1);
      check_eq("b_count", hs_cnt_b, 9);
      check_eq("b_left", exp_b.size(), 0);
      check_eq("b_e1_last", int'(b_e1), 254);
      check_eq("b_e2_last", int'(b_e2), 254);

      // Reset in SETTLE of point 7
      load_a();
      base = hs_cnt_a;
      pulse_start_a();
      wait_hs_a(base + 6, 500);
      start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      check_eq("sr_busy_before", int'(a_busy), 1);
      srst = 1'b1;
      @(posedge clk); #1 srst = 1'b0;
      check_reset_a("sr");
      exp_a.delete();
      base = hs_cnt_a;
      repeat (40) @(posedge clk);
      #1;
      check_eq("sr_no_result", hs_cnt_a - base, 0);
      check_eq("sr_valid", int'(a_valid), 0);
      check_eq("sr_busy", int'(a_busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
